// File: rtl/timer_prescaler_sel_if.sv
// Control and status bundle between a timer core and its clock prescaler/selector.
// The timer side drives the master modport; the prescaler implements the slave.
interface timer_prescaler_sel_if #(
    parameter int unsigned CTR_WIDTH = 10
);
    logic                 enable;
    logic                 psr;
    logic [2:0]           cs;
    logic                 ext_clk;
    logic                 tick;
    logic                 tap8;
    logic                 tap64;
    logic                 tap256;
    logic                 tap1024;
    logic                 ovf;
    logic [CTR_WIDTH-1:0] cnt;

    modport master (
        output enable, psr, cs, ext_clk,
        input  tick, tap8, tap64, tap256, tap1024, ovf, cnt
    );

    modport slave (
        input  enable, psr, cs, ext_clk,
        output tick, tap8, tap64, tap256, tap1024, ovf, cnt
    );
endinterface

// File: rtl/timer_prescaler_sel.sv
// Shared timer prescaler: free-running divider with /8../1024 taps and a wrap pulse,
// plus a clock-select mux that also offers a synchronised external clock edge.
module timer_prescaler_sel #(
    parameter int unsigned CTR_WIDTH   = 10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    timer_prescaler_sel_if.slave  bus
);

    localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;
    localparam int unsigned ARM_W      = $clog2(ARM_CYCLES + 1);

    localparam logic [2:0] CS_STOP = 3'd0;
    localparam logic [2:0] CS_DIV1 = 3'd1;
    localparam logic [2:0] CS_D8   = 3'd2;
    localparam logic [2:0] CS_D64  = 3'd3;
    localparam logic [2:0] CS_D256 = 3'd4;
    localparam logic [2:0] CS_D1K  = 3'd5;
    localparam logic [2:0] CS_FALL = 3'd6;
    localparam logic [2:0] CS_RISE = 3'd7;

    logic [CTR_WIDTH-1:0]   cnt_q,     cnt_d;
    logic                   tap8_q,    tap8_d;
    logic                   tap64_q,   tap64_d;
    logic                   tap256_q,  tap256_d;
    logic                   tap1024_q, tap1024_d;
    logic                   ovf_q,     ovf_d;
    logic                   en_q,      en_d;

    logic [SYNC_STAGES-1:0] sync_q,    sync_d;
    logic                   prev_q,    prev_d;
    logic                   rise_q,    rise_d;
    logic                   fall_q,    fall_d;
    logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
    logic                   arm_q,     arm_d;

    logic                   advance;
    logic                   ext_s;
    logic                   tick_c;

    assign advance = bus.enable & ~bus.psr;
    assign ext_s   = sync_q[SYNC_STAGES-1];

    // Divider: psr clears and wins over enable; enable low freezes the count.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.psr) begin
            cnt_d = '0;
        end else if (bus.enable) begin
            cnt_d = cnt_q + CTR_WIDTH'(1);
        end
    end

    // Taps fire on the cycle after the low bits saturate, only while advancing.
    always_comb begin
        tap8_d    = advance & (&cnt_q[2:0]);
        tap64_d   = advance & (&cnt_q[5:0]);
        tap256_d  = advance & (&cnt_q[7:0]);
        tap1024_d = advance & (&cnt_q[9:0]);
        ovf_d     = advance & (&cnt_q);
        en_d      = advance;
    end

    // Arm only once the synchroniser holds real pin samples, hiding the reset-release edge.
    always_comb begin
        arm_cnt_d = arm_cnt_q;
        arm_d     = arm_q;
        if (!arm_q) begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
            arm_d     = (arm_cnt_q == ARM_W'(SYNC_STAGES));
        end
    end

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.ext_clk};
        prev_d = ext_s;
        rise_d = arm_q & bus.enable & ext_s & ~prev_q;
        fall_d = arm_q & bus.enable & ~ext_s & prev_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            tap8_q    <= 1'b0;
            tap64_q   <= 1'b0;
            tap256_q  <= 1'b0;
            tap1024_q <= 1'b0;
            ovf_q     <= 1'b0;
            en_q      <= 1'b0;
            sync_q    <= '0;
            prev_q    <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            arm_cnt_q <= '0;
            arm_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tap8_q    <= tap8_d;
            tap64_q   <= tap64_d;
            tap256_q  <= tap256_d;
            tap1024_q <= tap1024_d;
            ovf_q     <= ovf_d;
            en_q      <= en_d;
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            arm_cnt_q <= arm_cnt_d;
            arm_q     <= arm_d;
        end
    end

    // Select is combinational over registered sources so a cs change acts immediately.
    always_comb begin
        tick_c = 1'b0;
        unique case (bus.cs)
            CS_STOP: tick_c = 1'b0;
            CS_DIV1: tick_c = en_q;
            CS_D8:   tick_c = tap8_q;
            CS_D64:  tick_c = tap64_q;
            CS_D256: tick_c = tap256_q;
            CS_D1K:  tick_c = tap1024_q;
            CS_FALL: tick_c = fall_q;
            CS_RISE: tick_c = rise_q;
            default: tick_c = 1'b0;
        endcase
    end

    assign bus.tick    = tick_c;
    assign bus.tap8    = tap8_q;
    assign bus.tap64   = tap64_q;
    assign bus.tap256  = tap256_q;
    assign bus.tap1024 = tap1024_q;
    assign bus.ovf     = ovf_q;
    assign bus.cnt     = cnt_q;

endmodule

// File: tb/tb_timer_prescaler_sel.sv
// Bench for timer_prescaler_sel: directed scenarios plus random traffic, every cycle
// compared against an arithmetic model built from edge counts since reset.
module tb_timer_prescaler_sel;

    localparam int unsigned SYNC = 2;
    localparam int unsigned M10  = 1024;
    localparam int unsigned M12  = 4096;

    logic clock = 1'b0;
    logic reset_n;

    timer_prescaler_sel_if #(.CTR_WIDTH(10)) bus ();
    timer_prescaler_sel_if #(.CTR_WIDTH(12)) bus12 ();

    timer_prescaler_sel #(.CTR_WIDTH(10), .SYNC_STAGES(SYNC)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    timer_prescaler_sel #(.CTR_WIDTH(12), .SYNC_STAGES(SYNC)) dut12 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus12)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: edges since reset, divider value, ext samples per edge.
    int since = 0;
    int m_cnt = 0;
    bit ext_h[$];
    bit e_tap8, e_tap64, e_tap256, e_tap1024, e_ovf, e_enq, e_rise, e_fall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, since);
        end
    endtask

    task automatic model_clear();
        since = 0;
        m_cnt = 0;
        ext_h.delete();
        {e_tap8, e_tap64, e_tap256, e_tap1024, e_ovf, e_enq, e_rise, e_fall} = '0;
    endtask

    function automatic bit sample_at(input int edge_no);
        return (edge_no >= 1) ? ext_h[edge_no-1] : 1'b0;
    endfunction

    task automatic model_edge(input bit en, input bit psr, input bit ext);
        int  prev;
        bit  act;
        bit  s_b, p_b, armed;
        since++;
        prev = m_cnt;
        act  = en && !psr;
        e_tap8    = act && (prev % 8    == 7);
        e_tap64   = act && (prev % 64   == 63);
        e_tap256  = act && (prev % 256  == 255);
        e_tap1024 = act && (prev % 1024 == 1023);
        e_ovf     = act && (prev == M10 - 1);
        e_enq     = act;
        if (psr)     m_cnt = 0;
        else if (en) m_cnt = (prev + 1) % M10;
        ext_h.push_back(ext);
        // Pin value seen SYNC edges ago versus the one before it.
        s_b   = sample_at(since - SYNC);
        p_b   = sample_at(since - SYNC - 1);
        armed = (since - 1) >= (SYNC + 1);
        e_rise = armed && en && s_b && !p_b;
        e_fall = armed && en && !s_b && p_b;
    endtask

    function automatic bit exp_tick(input logic [2:0] cs);
        case (cs)
            3'd1:    return e_enq;
            3'd2:    return e_tap8;
            3'd3:    return e_tap64;
            3'd4:    return e_tap256;
            3'd5:    return e_tap1024;
            3'd6:    return e_fall;
            3'd7:    return e_rise;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_all();
        bit o12, t12;
        o12 = (since >= 1) && ((since - 1) % M12 == M12 - 1);
        t12 = (since >= 1) && ((since - 1) % 1024 == 1023);
        chk("tick",    32'(bus.tick),    32'(exp_tick(bus.cs)));
        chk("tap8",    32'(bus.tap8),    32'(e_tap8));
        chk("tap64",   32'(bus.tap64),   32'(e_tap64));
        chk("tap256",  32'(bus.tap256),  32'(e_tap256));
        chk("tap1024", 32'(bus.tap1024), 32'(e_tap1024));
        chk("ovf",     32'(bus.ovf),     32'(e_ovf));
        chk("cnt",     32'(bus.cnt),     32'(m_cnt));
        chk("w12_ovf",     32'(bus12.ovf),     32'(o12));
        chk("w12_tap1024", 32'(bus12.tap1024), 32'(t12));
        chk("w12_cnt",     32'(bus12.cnt),     32'(since % M12));
    endtask

    task automatic step();
        @(posedge clock);
        if (!reset_n) model_clear();
        else          model_edge(bus.enable, bus.psr, bus.ext_clk);
        @(negedge clock);
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous assert mid-cycle, check immediately, then release on a falling edge.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1 model_clear();
        check_all();
        steps(3);
        reset_n = 1'b1;
    endtask

    task automatic square(input int n, input int half);
        for (int i = 0; i < n; i++) begin
            bus.ext_clk = ((i / half) % 2) == 0;
            step();
        end
    endtask

    task automatic run_to_cnt(input int target);
        for (int i = 0; i < 4 * M10 && m_cnt != target; i++) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hold;
        reset_n       = 1'b0;
        bus.enable    = 1'b1;
        bus.psr       = 1'b0;
        bus.cs        = 3'd2;
        bus.ext_clk   = 1'b0;
        bus12.enable  = 1'b1;
        bus12.psr     = 1'b0;
        bus12.cs      = 3'd5;
        bus12.ext_clk = 1'b0;
        model_clear();
        @(negedge clock);
        check_all();
        steps(2);
        reset_n = 1'b1;

        // /8 selection from release, through the first wrap.
        steps(1100);

        // psr at cnt=500 with /1024 selected.
        bus.cs = 3'd5;
        run_to_cnt(500);
        bus.psr = 1'b1;
        step();
        bus.psr = 1'b0;
        steps(1100);

        // Enable gap of 37 cycles mid-count.
        bus.cs = 3'd2;
        steps(13);
        bus.enable = 1'b0;
        steps(37);
        bus.enable = 1'b1;
        steps(50);

        // External clock, both edge selections.
        bus.cs = 3'd7;
        square(60, 5);
        bus.cs = 3'd6;
        square(60, 5);

        // Pin held high through reset must not look like a rising edge.
        bus.cs      = 3'd7;
        bus.ext_clk = 1'b1;
        do_reset();
        steps(20);
        bus.ext_clk = 1'b0;
        steps(4);
        bus.ext_clk = 1'b1;
        steps(6);

        // Asynchronous reset with /1 selected at cnt=300.
        bus.cs = 3'd1;
        run_to_cnt(300);
        do_reset();
        steps(5);

        // Random traffic, long enough for two wraps of the 12-bit divider.
        hold = 2;
        for (int i = 0; i < 9000; i++) begin
            if ($urandom_range(0, 31) == 0) bus.cs = 3'($urandom_range(0, 7));
            bus.enable = ($urandom_range(0, 9) != 0);
            bus.psr    = ($urandom_range(0, 39) == 0);
            hold--;
            if (hold <= 0) begin
                bus.ext_clk = ~bus.ext_clk;
                hold = int'($urandom_range(2, 6));
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
